// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase sequencer: fixed cycle, pedestrian walk/gap-out,
// and emergency pre-emption that is present only when TLC_PREEMPT_EN is defined.
module intersection_phase_scheduler #(
    parameter int TICK_DIV  = 500000,
    parameter int GREEN1_T  = 15,
    parameter int GREEN2_T  = 10,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 5,
    parameter int MIN_GREEN = 5,
    parameter int TEST_T    = 2
) (
    input  logic       clk,
    input  logic       standby,
    input  logic       test,
    input  logic       ped1_req,
    input  logic       ped2_req,
    input  logic       emerg_req,
    input  logic       emerg_road,
    output logic [2:0] light1,
    output logic [2:0] light2,
    output logic       walk1,
    output logic       walk2,
    output logic       ped1_pend,
    output logic       ped2_pend,
    output logic [2:0] phase,
    output logic [4:0] remain
);
    typedef enum logic [2:0] {
        YY = 3'd0, G1R2 = 3'd1, Y1R2 = 3'd2, AR_A = 3'd3,
        R1G2 = 3'd4, R1Y2 = 3'd5, AR_B = 3'd6, PRE = 3'd7
    } phase_t;

    localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [2:0]      LR = 3'b100;
    localparam logic [2:0]      LY = 3'b010;
    localparam logic [2:0]      LG = 3'b001;

    function automatic logic [4:0] dur_of(input phase_t p, input logic t);
        logic [4:0] d;
        case (p)
            G1R2:       d = t ? 5'(TEST_T) : 5'(GREEN1_T);
            R1G2:       d = t ? 5'(TEST_T) : 5'(GREEN2_T);
            AR_A, AR_B: d = 5'(ALLRED_T);
            PRE:        d = 5'd0;
            default:    d = t ? 5'(TEST_T) : 5'(YELLOW_T);
        endcase
        return d;
    endfunction

    function automatic logic [4:0] min5(input logic [4:0] a, input logic [4:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [5:0] lights_of(input phase_t p, input logic road);
        logic [5:0] l;
        case (p)
            YY:      l = {LY, LY};
            G1R2:    l = {LG, LR};
            Y1R2:    l = {LY, LR};
            R1G2:    l = {LR, LG};
            R1Y2:    l = {LR, LY};
            PRE:     l = road ? {LR, LG} : {LG, LR};
            default: l = {LR, LR};
        endcase
        return l;
    endfunction

    phase_t           phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       remain_q, remain_d;
    logic             test_q, test_d;
    logic             walk1_q, walk1_d, walk2_q, walk2_d;
    logic             pend1_q, pend1_d, pend2_q, pend2_d;
    logic             epend_q, epend_d, eroad_q, eroad_d;
    logic [2:0]       light1_q, light2_q;

    logic       emerg_s, emerg_road_s;
    logic       tick_s, exit_s, gap_s, enter_s, pre_act_s, road_s, walk_done_s;
    logic [4:0] dur_s, elapsed_s;

`ifdef TLC_PREEMPT_EN
    assign emerg_s      = emerg_req;
    assign emerg_road_s = emerg_road;
`else
    logic unused_emerg_s;
    assign emerg_s        = 1'b0;
    assign emerg_road_s   = 1'b0;
    assign unused_emerg_s = emerg_req ^ emerg_road;
`endif

    // Next-state: phase arbitration, second timing, walk and request latches.
    always_comb begin
        dur_s       = dur_of(phase_q, test_q);
        tick_s      = (phase_q != PRE) && (div_q == DIV_LAST);
        elapsed_s   = dur_s - remain_q + 5'd1;
        pre_act_s   = emerg_s || epend_q;
        road_s      = emerg_s ? emerg_road_s : eroad_q;
        gap_s       = tick_s && (elapsed_s >= min5(5'(MIN_GREEN), dur_s)) &&
                      (((phase_q == G1R2) && pend1_q) || ((phase_q == R1G2) && pend2_q));
        exit_s      = tick_s && ((remain_q == 5'd1) || gap_s);
        walk_done_s = tick_s && (elapsed_s >= min5(5'(WALK_T), dur_s));
        enter_s     = 1'b0;
        phase_d     = phase_q;
        // Pre-emption is checked before the timer so it beats a coincident gap-out.
        case (phase_q)
            YY, AR_B: begin
                if (exit_s) begin enter_s = 1'b1; phase_d = pre_act_s ? PRE : G1R2; end
                else begin enter_s = 1'b0; phase_d = phase_q; end
            end
            AR_A: begin
                if (exit_s) begin enter_s = 1'b1; phase_d = pre_act_s ? PRE : R1G2; end
                else begin enter_s = 1'b0; phase_d = phase_q; end
            end
            Y1R2: begin
                if (exit_s) begin enter_s = 1'b1; phase_d = AR_A; end
                else begin enter_s = 1'b0; phase_d = phase_q; end
            end
            R1Y2: begin
                if (exit_s) begin enter_s = 1'b1; phase_d = AR_B; end
                else begin enter_s = 1'b0; phase_d = phase_q; end
            end
            G1R2: begin
                if (pre_act_s) begin enter_s = 1'b1; phase_d = road_s ? Y1R2 : PRE; end
                else if (exit_s) begin enter_s = 1'b1; phase_d = Y1R2; end
                else begin enter_s = 1'b0; phase_d = phase_q; end
            end
            R1G2: begin
                if (pre_act_s) begin enter_s = 1'b1; phase_d = road_s ? PRE : R1Y2; end
                else if (exit_s) begin enter_s = 1'b1; phase_d = R1Y2; end
                else begin enter_s = 1'b0; phase_d = phase_q; end
            end
`ifdef TLC_PREEMPT_EN
            PRE: begin
                if (!emerg_s) begin enter_s = 1'b1; phase_d = eroad_q ? R1Y2 : Y1R2; end
                else begin enter_s = 1'b0; phase_d = PRE; end
            end
`endif
            default: begin enter_s = 1'b1; phase_d = YY; end
        endcase

        div_d = (enter_s || tick_s || (phase_q == PRE)) ? '0 : div_q + DIV_W'(1);

        if (enter_s) begin
            remain_d = dur_of(phase_d, test);
            test_d   = test;
        end else if (tick_s) begin
            remain_d = remain_q - 5'd1;
            test_d   = test_q;
        end else begin
            remain_d = remain_q;
            test_d   = test_q;
        end

        pend1_d = pend1_q | (ped1_req & ~walk1_q);
        pend2_d = pend2_q | (ped2_req & ~walk2_q);
        if (enter_s) begin
            walk1_d = (phase_d == R1G2) && pend1_q;
            walk2_d = (phase_d == G1R2) && pend2_q;
            if (walk1_d) pend1_d = 1'b0; else pend1_d = pend1_d;
            if (walk2_d) pend2_d = 1'b0; else pend2_d = pend2_d;
        end else begin
            walk1_d = walk1_q && !walk_done_s;
            walk2_d = walk2_q && !walk_done_s;
        end

        if ((phase_q != PRE) && emerg_s) begin
            epend_d = 1'b1;
            eroad_d = emerg_road_s;
        end else begin
            epend_d = epend_q;
            eroad_d = eroad_q;
        end
        if (enter_s && (phase_d == PRE)) epend_d = 1'b0; else epend_d = epend_d;
    end

    // State and output registers; reset is a YY entry that samples test.
    always_ff @(posedge clk) begin
        if (standby) begin
            phase_q  <= YY;
            div_q    <= '0;
            remain_q <= test ? 5'(TEST_T) : 5'(YELLOW_T);
            test_q   <= test;
            walk1_q  <= 1'b0;
            walk2_q  <= 1'b0;
            pend1_q  <= 1'b0;
            pend2_q  <= 1'b0;
            epend_q  <= 1'b0;
            eroad_q  <= 1'b0;
            light1_q <= LY;
            light2_q <= LY;
        end else begin
            phase_q  <= phase_d;
            div_q    <= div_d;
            remain_q <= remain_d;
            test_q   <= test_d;
            walk1_q  <= walk1_d;
            walk2_q  <= walk2_d;
            pend1_q  <= pend1_d;
            pend2_q  <= pend2_d;
            epend_q  <= epend_d;
            eroad_q  <= eroad_d;
            {light1_q, light2_q} <= lights_of(phase_d, eroad_d);
        end
    end

    assign phase     = phase_q;
    assign remain    = remain_q;
    assign light1    = light1_q;
    assign light2    = light2_q;
    assign walk1     = walk1_q;
    assign walk2     = walk2_q;
    assign ped1_pend = pend1_q;
    assign ped2_pend = pend2_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: directed scenarios plus random stimulus,
// every cycle compared against a seconds/cycle-count reference model.
module tb_intersection_phase_scheduler;
    localparam int TD = 4;
    localparam int G1 = 15, G2 = 10, YT = 3, AR = 1, WT = 5, MG = 5, TT = 2;

    logic       clk = 1'b0;
    logic       standby = 1'b1, test = 1'b0, ped1_req = 1'b0, ped2_req = 1'b0;
    logic       emerg_req = 1'b0, emerg_road = 1'b0;
    logic [2:0] light1, light2, phase;
    logic       walk1, walk2, ped1_pend, ped2_pend;
    logic [4:0] remain;

    intersection_phase_scheduler #(
        .TICK_DIV(TD), .GREEN1_T(G1), .GREEN2_T(G2), .YELLOW_T(YT),
        .ALLRED_T(AR), .WALK_T(WT), .MIN_GREEN(MG), .TEST_T(TT)
    ) dut (
        .clk(clk), .standby(standby), .test(test),
        .ped1_req(ped1_req), .ped2_req(ped2_req),
        .emerg_req(emerg_req), .emerg_road(emerg_road),
        .light1(light1), .light2(light2), .walk1(walk1), .walk2(walk2),
        .ped1_pend(ped1_pend), .ped2_pend(ped2_pend),
        .phase(phase), .remain(remain)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: phase, clocks spent in it, its length in seconds.
    int m_phase = 0, m_cyc = 0, m_dur = YT, m_wlen = 0;
    bit m_w1 = 1'b0, m_w2 = 1'b0, m_p1 = 1'b0, m_p2 = 1'b0, m_ep = 1'b0, m_er = 1'b0;

    logic [2:0] l1_tab [7] = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] l2_tab [7] = '{3'b010, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int seconds_for(input int ph, input bit t);
        if (ph == 3 || ph == 6) return AR;
        if (ph == 7) return 0;
        if (t) return TT;
        if (ph == 1) return G1;
        if (ph == 4) return G2;
        return YT;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int nxt, cyc1, el;
        bit act, np1, np2, gap;
        if (standby) begin
            m_phase = 0; m_cyc = 0; m_dur = seconds_for(0, test); m_wlen = 0;
            m_w1 = 0; m_w2 = 0; m_p1 = 0; m_p2 = 0; m_ep = 0; m_er = 0;
            return;
        end
        np1  = m_p1 | (ped1_req & ~m_w1);
        np2  = m_p2 | (ped2_req & ~m_w2);
        nxt  = -1;
        cyc1 = m_cyc + 1;
        el   = cyc1 / TD;
        act  = 1'b0;
`ifdef TLC_PREEMPT_EN
        begin
            bit road;
            act  = emerg_req || m_ep;
            road = emerg_req ? emerg_road : m_er;
            if (m_phase == 7) begin
                if (!emerg_req) nxt = m_er ? 5 : 2;
            end else if (act && m_phase == 1) nxt = road ? 2 : 7;
            else if (act && m_phase == 4) nxt = road ? 7 : 5;
            if (m_phase != 7 && emerg_req) begin m_ep = 1; m_er = emerg_road; end
        end
`endif
        if (nxt < 0 && m_phase != 7 && (cyc1 % TD) == 0) begin
            gap = ((m_phase == 1 && m_p1) || (m_phase == 4 && m_p2)) && el >= imin(MG, m_dur);
            if (el >= m_dur || gap) begin
                case (m_phase)
                    0, 6:    nxt = act ? 7 : 1;
                    3:       nxt = act ? 7 : 4;
                    1:       nxt = 2;
                    2:       nxt = 3;
                    4:       nxt = 5;
                    5:       nxt = 6;
                    default: nxt = 0;
                endcase
            end
        end
        if (nxt >= 0) begin
            if (nxt == 7) m_ep = 0;
            m_w1 = (nxt == 4) && m_p1;
            m_w2 = (nxt == 1) && m_p2;
            if (m_w1) np1 = 0;
            if (m_w2) np2 = 0;
            m_phase = nxt; m_cyc = 0;
            m_dur = seconds_for(nxt, test);
            m_wlen = imin(WT, m_dur);
        end else begin
            m_cyc = cyc1;
            if (cyc1 >= m_wlen * TD) begin m_w1 = 0; m_w2 = 0; end
        end
        m_p1 = np1;
        m_p2 = np2;
    endtask

    task automatic compare_model();
        logic [2:0] e1, e2;
        int er;
        if (m_phase == 7) begin
            e1 = m_er ? 3'b100 : 3'b001;
            e2 = m_er ? 3'b001 : 3'b100;
            er = 0;
        end else begin
            e1 = l1_tab[m_phase];
            e2 = l2_tab[m_phase];
            er = m_dur - m_cyc / TD;
        end
        check("phase",  8'(phase),     8'(m_phase));
        check("light1", 8'(light1),    8'(e1));
        check("light2", 8'(light2),    8'(e2));
        check("remain", 8'(remain),    8'(er));
        check("walk1",  8'(walk1),     8'(m_w1));
        check("walk2",  8'(walk2),     8'(m_w2));
        check("pend1",  8'(ped1_pend), 8'(m_p1));
        check("pend2",  8'(ped2_pend), 8'(m_p2));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic expect_run(input int ph, input int len, input string tag);
        for (int k = 0; k < len; k++) begin
            check(tag, 8'(phase), 8'(ph));
            cycle();
        end
    endtask

    task automatic do_reset();
        standby = 1'b1;
        cycle();
        standby = 1'b0;
    endtask

    task automatic idle_sequence(input string tag);
        int ph_tab [8] = '{0, 1, 2, 3, 4, 5, 6, 1};
        int ln_tab [8] = '{12, 60, 12, 4, 40, 12, 4, 1};
        for (int i = 0; i < 8; i++) expect_run(ph_tab[i], ln_tab[i], tag);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_phase",  8'(phase),  8'd0);
        check("rst_light1", 8'(light1), 8'h02);
        check("rst_light2", 8'(light2), 8'h02);
        check("rst_remain", 8'(remain), 8'd3);
        check("rst_walk",   8'({walk1, walk2}), 8'd0);
        check("rst_pend",   8'({ped1_pend, ped2_pend}), 8'd0);

        // Idle cycle
        idle_sequence("idle_seq");

        // Pedestrian gap-out on road 1, walk, then standby mid-walk
        do_reset();
        expect_run(0, 12, "ped_yy");
        expect_run(1, 4, "ped_g1");
        ped1_req = 1'b1;
        expect_run(1, 1, "ped_g1");
        ped1_req = 1'b0;
        expect_run(1, 15, "ped_g1_gap");
        expect_run(2, 12, "ped_y1");
        expect_run(3, 4, "ped_ara");
        check("ped_walk1_on",  8'(walk1),     8'd1);
        check("ped_pend1_clr", 8'(ped1_pend), 8'd0);
        expect_run(4, 2, "ped_r1g2");
        ped2_req = 1'b1;
        expect_run(4, 1, "ped_r1g2");
        ped2_req = 1'b0;
        check("ped_pend2_set", 8'(ped2_pend), 8'd1);
        check("ped_walk1_mid", 8'(walk1),     8'd1);
        standby = 1'b1;
        cycle();
        standby = 1'b0;
        check("sb_phase",  8'(phase),  8'd0);
        check("sb_walk1",  8'(walk1),  8'd0);
        check("sb_remain", 8'(remain), 8'd3);
        check("sb_pend",   8'({ped1_pend, ped2_pend}), 8'd0);

        // Walk length boundary: walk1 drops after exactly WALK_T seconds
        expect_run(0, 12, "wb_yy");
        ped1_req = 1'b1;
        expect_run(1, 1, "wb_g1");
        ped1_req = 1'b0;
        expect_run(1, 19, "wb_g1");
        expect_run(2, 12, "wb_y1");
        expect_run(3, 4, "wb_ara");
        expect_run(4, 20, "wb_r1g2");
        check("wb_walk1_off", 8'(walk1), 8'd0);

        // Test mode from reset
        test = 1'b1;
        do_reset();
        expect_run(0, 8, "tst_yy");
        expect_run(1, 8, "tst_g1");
        expect_run(2, 8, "tst_y1");
        expect_run(3, 4, "tst_ara");
        check("tst_r1g2", 8'(phase), 8'd4);
        test = 1'b0;

`ifdef TLC_PREEMPT_EN
        // Pre-emption for road 2 during G1R2
        do_reset();
        expect_run(0, 12, "pre_yy");
        expect_run(1, 8, "pre_g1");
        emerg_req = 1'b1; emerg_road = 1'b1;
        cycle();
        check("pre_y1_phase",  8'(phase),  8'd2);
        check("pre_y1_remain", 8'(remain), 8'd3);
        expect_run(2, 12, "pre_y1");
        expect_run(3, 4, "pre_ara");
        check("pre_light2", 8'(light2), 8'h01);
        check("pre_remain", 8'(remain), 8'd0);
        emerg_road = 1'b0;
        expect_run(7, 3, "pre_hold");
        emerg_req = 1'b0;
        expect_run(7, 1, "pre_hold");
        expect_run(5, 12, "pre_r1y2");
        expect_run(6, 4, "pre_arb");
        check("pre_resume", 8'(phase), 8'd1);
`else
        // Emergency inputs have no effect in this build
        emerg_req = 1'b1;
        emerg_road = 1'b1;
        do_reset();
        idle_sequence("emerg_ignored");
        emerg_req = 1'b0;
`endif

        // Random stimulus against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ped1_req = ($urandom_range(0, 99) < 3);
            ped2_req = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 2) emerg_req = ~emerg_req;
            if ($urandom_range(0, 99) < 5) emerg_road = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 1) test = ~test;
            standby = ($urandom_range(0, 999) < 2);
            cycle();
        end
        standby = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
